block_serial_skip_adder: RTL and testbench
==========================================

Name: block_serial_skip_adder

Overview:
Sequential operand-issue and accumulate stage for the carry-skip adder datapath. It accepts one operand pair per transaction over a valid/ready handshake and processes one BLOCK_SIZE slice per clock. Each slice uses ripple carry plus a block-skip mux. The stage returns sum, carry-out, signed overflow and a skip-usage count over a second valid/ready handshake. It trades latency for area in front of consumers that cannot close timing on a full-width combinational adder.

Parameters:
DATA_WIDTH, 32, operand/sum width in bits (>=1)
BLOCK_SIZE, 4, bits processed per cycle; the last block may be partial
Derived constants: NUM_BLOCKS = ceil(DATA_WIDTH/BLOCK_SIZE); CW = $clog2(NUM_BLOCKS+1)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair presented
in_ready  output  1  stage can accept operands this cycle
a  input  DATA_WIDTH  operand A
b  input  DATA_WIDTH  operand B
cin  input  1  carry-in
sub  input  1  1 = subtract: b_eff = ~b, c_eff = cin ^ 1; 0 = add: b_eff = b, c_eff = cin
out_valid  output  1  result available
out_ready  input  1  consumer takes result
sum  output  DATA_WIDTH  a + b_eff + c_eff, modulo 2^DATA_WIDTH
cout  output  1  carry out of MSB
overflow  output  1  signed overflow: (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB])
skip_count  output  CW  number of blocks whose all-propagate skip path was taken

Behaviour:
- Reset (async assert, sync deassert handled by the flop): state=IDLE. in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, skip_count=0. Block index and carry register are cleared. Any in-flight transaction is discarded with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b_eff and c_eff into registers, set blk=0 and carry=c_eff, clear sum and skip_count, then go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle processes block blk, bits [blk*BLOCK_SIZE .. min(DATA_WIDTH, (blk+1)*BLOCK_SIZE)-1]:
    - p = a ^ b_eff. Ripple the slice from carry and write the slice sum bits.
    - blkprop = AND of the slice p bits.
    - carry <= blkprop ? carry : ripple_cout.
    - skip_count += blkprop.
    - blk increments. When blk == NUM_BLOCKS-1, set cout from the new carry, compute overflow, go to DONE.
  - DONE: out_valid=1 and all outputs held stable.
    - in_ready = out_ready.
    - out_ready=1 with in_valid=1 accepts the next operands in the same cycle and goes to RUN (no bubble).
    - out_ready=1 with in_valid=0 goes to IDLE.
    - out_ready=0 keeps DONE with outputs unchanged.
- Latency: for operands accepted on edge T, out_valid rises on edge T+NUM_BLOCKS. Throughput is one result per NUM_BLOCKS cycles when the consumer is always ready.
- Skip semantics: the carry result must equal the pure ripple result. When blkprop=1 the ripple cout equals the carry-in, so the skip mux is functionally transparent; skip_count only records the path taken.
- Partial last block: only the valid bits participate; blkprop is computed over those bits only.
- in_valid while in RUN: ignored (in_ready=0). The upstream must hold its data.
- Outputs (sum, cout, overflow, skip_count) are registered. Values are undefined-free but meaningful only while out_valid=1.
- NUM_BLOCKS=1 (BLOCK_SIZE >= DATA_WIDTH): a single RUN cycle, latency 1.

Test Plan:
- W=32, B=4: a=0x00000001, b=0x00000002, cin=0, sub=0 -> sum=0x00000003, cout=0, overflow=0, skip_count=0; out_valid exactly 8 cycles after accept.
- a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, overflow=0, skip_count=8.
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, overflow=1, skip_count=6. sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 in the same cycle -> new pair accepted that cycle and the next result arrives 8 cycles later.
- Assert rst during RUN at blk=3 -> out_valid=0, in_ready=1, outputs zero immediately. The next transaction (a=0x10, b=0x20) yields sum=0x30 with no residue.
- W=10, B=4 (3 blocks, last block 2 bits): a=0x3FF, b=0x001 -> sum=0x000, cout=1, skip_count=2, latency 3.

Source files
------------

// File: rtl/block_serial_skip_adder.sv
// rtl/block_serial_skip_adder.sv - block-serial carry-skip adder, one slice per clock
module block_serial_skip_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  localparam int NUM_BLOCKS = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE,
  localparam int CW = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow,
  output logic [CW-1:0]         skip_count
);

  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_eff_reg;
  logic                  carry;
  logic [BW-1:0]         blk;

  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  ripple_c;
  logic                  blkprop;
  logic                  carry_next;
  logic                  last_blk;
  logic                  load;

  assign p        = a_reg ^ b_eff_reg;
  assign g        = a_reg & b_eff_reg;
  assign last_blk = (blk == BW'(NUM_BLOCKS - 1));

  // The next operand pair is taken from IDLE, or from DONE in the same cycle the result leaves
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign load     = in_valid && in_ready;

  // Ripple the current slice; bits beyond DATA_WIDTH in a partial last block are ignored
  always_comb begin
    sum_next = sum;
    ripple_c = carry;
    blkprop  = 1'b1;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      int idx;
      idx = int'(blk) * BLOCK_SIZE + i;
      if (idx < DATA_WIDTH) begin
        sum_next[IW'(idx)] = p[IW'(idx)] ^ ripple_c;
        ripple_c           = g[IW'(idx)] | (p[IW'(idx)] & ripple_c);
        blkprop            = blkprop & p[IW'(idx)];
      end
    end
    // An all-propagate slice passes its carry-in straight through the skip mux
    carry_next = blkprop ? carry : ripple_c;
  end

  // Control FSM with the operand, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_eff_reg  <= '0;
      carry      <= 1'b0;
      blk        <= '0;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
      skip_count <= '0;
    end else if (load) begin
      a_reg      <= a;
      b_eff_reg  <= sub ? ~b : b;
      carry      <= cin ^ sub;
      blk        <= '0;
      sum        <= '0;
      skip_count <= '0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      state      <= RUN;
    end else begin
      case (state)
        RUN: begin
          sum        <= sum_next;
          carry      <= carry_next;
          skip_count <= skip_count + CW'(blkprop);
          blk        <= blk + BW'(1);
          if (last_blk) begin
            cout      <= carry_next;
            overflow  <= (a_reg[DATA_WIDTH-1] == b_eff_reg[DATA_WIDTH-1]) &&
                         (sum_next[DATA_WIDTH-1] != a_reg[DATA_WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_serial_skip_adder.sv
// tb/tb_block_serial_skip_adder.sv - scoreboard bench for block_serial_skip_adder
module tb_block_serial_skip_adder;

  localparam int W   = 32;
  localparam int W2  = 10;
  localparam int B   = 4;
  localparam int NB  = 8;
  localparam int NB2 = 3;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          skip;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv_a, iv_b, ir_a, ir_b, ov_a, ov_b;
  logic        out_ready, cin, sub;
  logic [31:0] a, b;
  logic [31:0] sum_a;
  logic [9:0]  sum_b;
  logic        cout_a, cout_b, ovf_a, ovf_b;
  logic [3:0]  skip_a;
  logic [1:0]  skip_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic pv_a    = 1'b0;
  logic pv_b    = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  block_serial_skip_adder #(.DATA_WIDTH(W), .BLOCK_SIZE(B)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov_a), .out_ready(out_ready),
    .sum(sum_a), .cout(cout_a), .overflow(ovf_a), .skip_count(skip_a));

  block_serial_skip_adder #(.DATA_WIDTH(W2), .BLOCK_SIZE(B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .a(a[9:0]), .b(b[9:0]),
    .cin(cin), .sub(sub), .out_valid(ov_b), .out_ready(out_ready),
    .sum(sum_b), .cout(cout_b), .overflow(ovf_b), .skip_count(skip_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int w, input int bs, input logic [31:0] aa,
                                 input logic [31:0] bb, input logic cc, input logic ss);
    logic [63:0] mask, aw, beff, tot, pp, sm, t;
    exp_t e;
    mask  = (64'd1 << w) - 64'd1;
    aw    = {32'd0, aa} & mask;
    beff  = (ss ? ~{32'd0, bb} : {32'd0, bb}) & mask;
    tot   = aw + beff + 64'(cc ^ ss);
    e.sum = 32'(tot & mask);
    t     = tot >> w;
    e.cout = t[0];
    e.ovf  = ((aw >> (w - 1)) & 64'd1) == ((beff >> (w - 1)) & 64'd1) &&
             ((tot >> (w - 1)) & 64'd1) != ((aw >> (w - 1)) & 64'd1);
    pp     = (aw ^ beff) & mask;
    e.skip = 0;
    for (int lo = 0; lo < w; lo += bs) begin
      int n;
      n  = (w - lo < bs) ? (w - lo) : bs;
      sm = (64'd1 << n) - 64'd1;
      if (((pp >> lo) & sm) == sm) e.skip++;
    end
    e.acc = 0;
    return e;
  endfunction

  // Scoreboard: latency on each out_valid rise, values on each output handshake
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      pv_a = 1'b0;
      pv_b = 1'b0;
    end else begin
      if (ov_a && !pv_a) begin
        if (q_a.size() == 0) check("a_spurious_valid", 64'(ov_a), 64'(0));
        else check("a_latency", 64'(cyc - q_a[0].acc), 64'(NB));
      end
      if (ov_a && out_ready && q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_sum", 64'(sum_a), 64'(e.sum));
        check("a_cout", 64'(cout_a), 64'(e.cout));
        check("a_ovf", 64'(ovf_a), 64'(e.ovf));
        check("a_skip", 64'(skip_a), 64'(e.skip));
      end
      if (ov_b && !pv_b) begin
        if (q_b.size() == 0) check("b_spurious_valid", 64'(ov_b), 64'(0));
        else check("b_latency", 64'(cyc - q_b[0].acc), 64'(NB2));
      end
      if (ov_b && out_ready && q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_sum", 64'(sum_b), 64'(e.sum));
        check("b_cout", 64'(cout_b), 64'(e.cout));
        check("b_ovf", 64'(ovf_b), 64'(e.ovf));
        check("b_skip", 64'(skip_b), 64'(e.skip));
      end
      pv_a = ov_a;
      pv_b = ov_b;
    end
  end

  task automatic send(input bit to_b, input logic [31:0] aa, input logic [31:0] bb,
                      input logic cc, input logic ss);
    int   n;
    exp_t e;
    @(negedge clk);
    a = aa; b = bb; cin = cc; sub = ss;
    if (to_b) iv_b = 1'b1; else iv_a = 1'b1;
    #1;
    n = 0;
    while (!(to_b ? ir_b : ir_a) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(to_b ? "b_accept" : "a_accept", 64'(to_b ? ir_b : ir_a), 64'(1));
    e = model(to_b ? W2 : W, B, aa, bb, cc, ss);
    e.acc = cyc + 1;
    if (to_b) q_b.push_back(e); else q_a.push_back(e);
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 64'(q_a.size() + q_b.size()), 64'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 64'(ir_a), 64'(1));
    check({tag, "_out_valid"}, 64'(ov_a), 64'(0));
    check({tag, "_sum"}, 64'(sum_a), 64'(0));
    check({tag, "_cout"}, 64'(cout_a), 64'(0));
    check({tag, "_ovf"}, 64'(ovf_a), 64'(0));
    check({tag, "_skip"}, 64'(skip_a), 64'(0));
  endtask

  initial begin
    exp_t held, e;
    int   n;
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("rst");
    check("rst_b_in_ready", 64'(ir_b), 64'(1));
    check("rst_b_out_valid", 64'(ov_b), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    send(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    wait_drain();

    // Backpressure: hold the result, then release it with a new pair in the same cycle
    out_ready = 1'b0;
    send(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    held = q_a[0];
    n = 0;
    while (!ov_a && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", 64'(ov_a), 64'(1));
      check("bp_in_ready", 64'(ir_a), 64'(0));
      check("bp_sum", 64'(sum_a), 64'(held.sum));
      check("bp_skip", 64'(skip_a), 64'(held.skip));
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'hCAFE_0001; b = 32'h3501_FFFF; cin = 1'b1; sub = 1'b0; iv_a = 1'b1;
    #1;
    check("bp_in_ready_follow", 64'(ir_a), 64'(1));
    e = model(W, B, 32'hCAFE_0001, 32'h3501_FFFF, 1'b1, 1'b0);
    e.acc = cyc + 1;
    q_a.push_back(e);
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    wait_drain();

    // Reset while the fourth block is being processed
    send(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    send(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    wait_drain();

    // Ten-bit instance with a two-bit last block
    send(1, 32'h0000_03FF, 32'h0000_0001, 1'b0, 1'b0);
    send(1, 32'h0000_0200, 32'h0000_0200, 1'b0, 1'b0);
    send(1, 32'h0000_0155, 32'h0000_02AA, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
